ex_alu_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline. Consumes the 4-bit ALU control code produced by ALU control decoding together with ID/EX operands, computes the ALU result and zero flag, resolves BEQ, and holds everything in the EX/MEM pipeline register. Upstream and downstream traffic uses a valid/ready handshake. Flush inserts a bubble.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 33 +++
 rtl/ex_alu_stage.sv | 117 +++++++++++
 tb/tb_ex_alu_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the execute stage, the ALU control decoder and the
// single-cycle build.
package alu_pkg;

    // 4-bit ALU control codes produced by ALU control decoding
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // 2-bit ALUOp from the main decoder to the ALU control decoder
    localparam logic [1:0] ALUOP_MEM   = 2'b00;  // LW/SW address add
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;  // compare by subtraction
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // use funct field

    // True for every control code the ALU implements
    function automatic logic alu_ctrl_supported(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR)  || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: result, zero flag and unsupported-code flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             bad_op
);

    // Operation select; unsupported codes yield 0 so zero reads 1
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        result = '0;
        bad_op = 1'b0;
        case (alu_ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: bad_op = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: ALU, BEQ resolution and the EX/MEM pipeline register
// behind a single-entry valid/ready handshake.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_ctrl,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [WIDTH-1:0]    store_data,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic                reg_write_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                mem_to_reg_in,
    input  logic                branch_in,
    input  logic [WIDTH-1:0]    branch_target,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_result,
    output logic                zero,
    output logic [WIDTH-1:0]    store_data_out,
    output logic [REG_BITS-1:0] rd_out,
    output logic                reg_write_out,
    output logic                mem_read_out,
    output logic                mem_write_out,
    output logic                mem_to_reg_out,
    output logic                branch_taken,
    output logic [WIDTH-1:0]    pc_redirect,
    output logic                bad_op
);

    // EX/MEM register contents
    typedef struct packed {
        logic [WIDTH-1:0]    result;
        logic                zero;
        logic                bad_op;
        logic [WIDTH-1:0]    store_data;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic [WIDTH-1:0]    target;
    } exmem_t;

    exmem_t           entry_q;
    logic             valid_q;
    logic             branch_pulse_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_bad;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_res),
        .zero     (alu_zero),
        .bad_op   (alu_bad)
    );

    // Single-entry register: ready when empty or draining this cycle
    assign in_ready = !valid_q || out_ready;

    // EX/MEM register, valid bit and the one-shot branch pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            branch_pulse_q <= 1'b0;
            entry_q        <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            // The pulse is set only by a fresh accept, so a stalled BEQ never repeats it.
            branch_pulse_q <= 1'b0;
            if (in_ready) begin
                valid_q <= in_valid && !flush;
                if (in_valid) begin
                    entry_q.result     <= alu_res;
                    entry_q.zero       <= alu_zero;
                    entry_q.bad_op     <= alu_bad;
                    entry_q.store_data <= store_data;
                    entry_q.rd         <= rd_in;
                    entry_q.reg_write  <= reg_write_in;
                    entry_q.mem_read   <= mem_read_in;
                    entry_q.mem_write  <= mem_write_in;
                    entry_q.mem_to_reg <= mem_to_reg_in;
                    entry_q.target     <= branch_target;
                    branch_pulse_q     <= !flush && branch_in && alu_zero;
                end
            end
        end
    end

    // Side-effecting controls are masked by valid so a bubble does nothing
    assign out_valid      = valid_q;
    assign alu_result     = entry_q.result;
    assign zero           = entry_q.zero;
    assign store_data_out = entry_q.store_data;
    assign rd_out         = entry_q.rd;
    assign mem_to_reg_out = entry_q.mem_to_reg;
    assign pc_redirect    = entry_q.target;
    assign reg_write_out  = valid_q && entry_q.reg_write;
    assign mem_read_out   = valid_q && entry_q.mem_read;
    assign mem_write_out  = valid_q && entry_q.mem_write;
    assign bad_op         = valid_q && entry_q.bad_op;
    assign branch_taken   = valid_q && branch_pulse_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ex_alu_stage;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a, op_b, store_data, branch_target;
    logic [R-1:0] rd_in;
    logic         reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in;
    logic         flush, out_valid, out_ready;
    logic [W-1:0] alu_result, store_data_out, pc_redirect;
    logic         zero;
    logic [R-1:0] rd_out;
    logic         reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
    logic         branch_taken, bad_op;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_alu_stage #(.WIDTH(W), .REG_BITS(R)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .store_data(store_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .branch_in(branch_in), .branch_target(branch_target),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero),
        .store_data_out(store_data_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .branch_taken(branch_taken), .pc_redirect(pc_redirect), .bad_op(bad_op)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_ctrl = 4'd0; op_a = '0; op_b = '0; store_data = '0;
        rd_in = '0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
        mem_to_reg_in = 0; branch_in = 0; branch_target = '0; flush = 0; out_ready = 1;
    endtask

    // Reference ALU written from the operation list, using integer arithmetic
    function automatic void ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] res,
                                    output logic bad);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bad = 0;
        if (c == 4'd0)       res = a & b;
        else if (c == 4'd1)  res = a | b;
        else if (c == 4'd2)  res = W'((longint'(a) + longint'(b)) % (64'd1 << W));
        else if (c == 4'd6)  res = W'((longint'(a) - longint'(b) + (64'd1 << W)) % (64'd1 << W));
        else if (c == 4'd7)  res = (sa < sb) ? 1 : 0;
        else if (c == 4'd12) res = ~(a | b);
        else begin res = 0; bad = 1; end
    endfunction

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a, b, exp_res;
        logic         exp_zero, exp_bad;
    } vec_t;

    vec_t vecs[9];

    // Reference model state: what EX/MEM should hold
    logic         m_valid, m_bt, m_rw, m_mw, m_mr, m_zero, m_bad;
    logic [W-1:0] m_res, m_tgt;
    logic [R-1:0] m_rd;

    initial begin
        vecs[0] = '{4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0};
        vecs[1] = '{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0};
        vecs[2] = '{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
        vecs[3] = '{4'b0110, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0};
        vecs[4] = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0};
        vecs[5] = '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0};
        vecs[6] = '{4'b1100, 32'h0000_FFFF, 32'hFF00_0000, 32'h00FF_0000, 1'b0, 1'b0};
        vecs[7] = '{4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 32'h1234_5678, 32'h9,         32'h0,         1'b1, 1'b1};

        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        check("reset out_valid", W'(out_valid), 0);
        check("reset in_ready", W'(in_ready), 1);
        check("reset alu_result", alu_result, 0);
        check("reset branch_taken", W'(branch_taken), 0);

        // Back-to-back stream from the vector table
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; alu_ctrl = vecs[i].ctrl; op_a = vecs[i].a; op_b = vecs[i].b;
            rd_in = R'(i + 1); reg_write_in = 1;
            tick();
            check($sformatf("vec%0d out_valid", i), W'(out_valid), 1);
            check($sformatf("vec%0d result", i), alu_result, vecs[i].exp_res);
            check($sformatf("vec%0d zero", i), W'(zero), W'(vecs[i].exp_zero));
            check($sformatf("vec%0d bad_op", i), W'(bad_op), W'(vecs[i].exp_bad));
            check($sformatf("vec%0d rd", i), W'(rd_out), W'(i + 1));
        end
        idle_inputs();
        tick();
        check("drain out_valid", W'(out_valid), 0);

        // BEQ taken, then held through a 3-cycle stall
        in_valid = 1; alu_ctrl = 4'b0110; op_a = 5; op_b = 5; branch_in = 1;
        branch_target = 32'h40;
        tick();
        check("beq branch_taken", W'(branch_taken), 1);
        check("beq pc_redirect", pc_redirect, 32'h40);
        check("beq zero", W'(zero), 1);
        alu_ctrl = 4'b0010; op_a = 7; op_b = 8; branch_in = 0; branch_target = 32'h99;
        out_ready = 0;
        #1;
        check("stall in_ready", W'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d branch_taken", i), W'(branch_taken), 0);
            check($sformatf("stall%0d out_valid", i), W'(out_valid), 1);
            check($sformatf("stall%0d result", i), alu_result, 0);
            check($sformatf("stall%0d pc_redirect", i), pc_redirect, 32'h40);
            check($sformatf("stall%0d in_ready", i), W'(in_ready), 0);
        end
        out_ready = 1;
        tick();
        check("post-stall result", alu_result, 15);
        check("post-stall branch_taken", W'(branch_taken), 0);

        // Flush of a SW in the accept cycle
        idle_inputs();
        in_valid = 1; alu_ctrl = 4'b0010; op_a = 32'h100; op_b = 4; mem_write_in = 1;
        store_data = 32'hDEAD_BEEF; flush = 1;
        tick();
        check("flush out_valid", W'(out_valid), 0);
        check("flush mem_write_out", W'(mem_write_out), 0);

        // Flush during a stall leaves the held entry alone
        flush = 0;
        tick();
        check("sw out_valid", W'(out_valid), 1);
        check("sw mem_write_out", W'(mem_write_out), 1);
        check("sw store_data", store_data_out, 32'hDEAD_BEEF);
        out_ready = 0; flush = 1; mem_write_in = 0;
        tick();
        check("stall+flush out_valid", W'(out_valid), 1);
        check("stall+flush mem_write_out", W'(mem_write_out), 1);

        // Reset during a stall, with a taken BEQ presented
        flush = 0; alu_ctrl = 4'b0110; op_a = 3; op_b = 3; branch_in = 1; branch_target = 32'h80;
        rst = 1;
        tick();
        rst = 0;
        check("rst-stall out_valid", W'(out_valid), 0);
        check("rst-stall in_ready", W'(in_ready), 1);
        check("rst-stall result", alu_result, 0);
        check("rst-stall store_data", store_data_out, 0);
        check("rst-stall mem_write_out", W'(mem_write_out), 0);
        check("rst-stall branch_taken", W'(branch_taken), 0);
        check("rst-stall pc_redirect", pc_redirect, 0);
        idle_inputs();
        tick();

        // Randomized traffic against the transaction model
        m_valid = out_valid; m_bt = 0; m_rw = 0; m_mw = 0; m_mr = 0;
        m_zero = 0; m_bad = 0; m_res = 0; m_tgt = 0; m_rd = 0;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] codes[7];
            logic [W-1:0] r;
            logic b;
            codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd9};
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            alu_ctrl      = codes[$urandom_range(0, 6)];
            op_a          = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
            op_b          = ($urandom_range(0, 2) == 0) ? op_a : $urandom;
            rd_in         = R'($urandom);
            reg_write_in  = 1'($urandom);
            mem_read_in   = 1'($urandom);
            mem_write_in  = 1'($urandom);
            branch_in     = 1'($urandom);
            branch_target = $urandom;
            #1;
            check("rand in_ready", W'(in_ready), W'(!m_valid || out_ready));
            if (!m_valid || out_ready) begin
                m_bt = 0;
                if (in_valid) begin
                    ref_alu(alu_ctrl, op_a, op_b, r, b);
                    m_res = r; m_bad = b; m_zero = (r == 0);
                    m_rd = rd_in; m_rw = reg_write_in; m_mr = mem_read_in;
                    m_mw = mem_write_in; m_tgt = branch_target;
                    m_valid = !flush;
                    m_bt = !flush && branch_in && (r == 0);
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_bt = 0;
            end
            tick();
            check("rand out_valid", W'(out_valid), W'(m_valid));
            check("rand branch_taken", W'(branch_taken), W'(m_bt));
            check("rand reg_write_out", W'(reg_write_out), W'(m_valid && m_rw));
            check("rand mem_write_out", W'(mem_write_out), W'(m_valid && m_mw));
            check("rand mem_read_out", W'(mem_read_out), W'(m_valid && m_mr));
            check("rand bad_op", W'(bad_op), W'(m_valid && m_bad));
            if (m_valid) begin
                check("rand result", alu_result, m_res);
                check("rand zero", W'(zero), W'(m_zero));
                check("rand rd", W'(rd_out), W'(m_rd));
                check("rand pc_redirect", pc_redirect, m_tgt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
